// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared encodings, state enum and forwarding rule
// for the 5-stage pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  localparam logic [2:0] PCSRC_SEQ = 3'b000;
  localparam logic [2:0] PCSRC_J   = 3'b001;
  localparam logic [2:0] PCSRC_JR  = 3'b010;
  localparam logic [2:0] PCSRC_BR  = 3'b100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [5:0] OP_J_DEF  = 6'h02;
  localparam logic [5:0] OP_JR_DEF = 6'h08;

  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_e;

  typedef struct packed {
    logic       pc_write;
    logic       ifid_write;
    logic       if_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic [2:0] pc_src;
  } ctl_t;

  localparam ctl_t CTL_RESET = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, PCSRC_SEQ};
  localparam ctl_t CTL_SEQ   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PCSRC_SEQ};
  localparam ctl_t CTL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, PCSRC_SEQ};
  localparam ctl_t CTL_BR    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, PCSRC_BR};
  localparam ctl_t CTL_J     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, PCSRC_J};
  localparam ctl_t CTL_JR    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, PCSRC_JR};

  // MEM result is newer than WB, so it wins; r0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic mem_we, input logic [4:0] mem_rd,
                                         input logic wb_we, input logic [4:0] wb_rd,
                                         input logic [4:0] src);
    return (mem_we && mem_rd != 5'd0 && mem_rd == src) ? FWD_MEM :
           (wb_we && wb_rd != 5'd0 && wb_rd == src)    ? FWD_WB  : FWD_RF;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_forward_unit.sv
// forward_unit: combinational EX-stage operand forwarding selects.
module forward_unit
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       en_i,
  input  logic       exmem_we_i,
  input  logic [4:0] exmem_rd_i,
  input  logic       memwb_we_i,
  input  logic [4:0] memwb_rd_i,
  input  logic [4:0] idex_rs_i,
  input  logic [4:0] idex_rt_i,
  output logic [1:0] fwd_a_o,
  output logic [1:0] fwd_b_o
);

  assign fwd_a_o = en_i ? fwd_sel(exmem_we_i, exmem_rd_i, memwb_we_i, memwb_rd_i, idex_rs_i) : FWD_RF;
  assign fwd_b_o = en_i ? fwd_sel(exmem_we_i, exmem_rd_i, memwb_we_i, memwb_rd_i, idex_rt_i) : FWD_RF;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect sequencing and forwarding selects
// for the 5-stage pipeline, with saturating stall and flush counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter logic [5:0] OP_J  = OP_J_DEF,
  parameter logic [5:0] OP_JR = OP_JR_DEF,
  parameter int         CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [5:0]       ifid_opCode,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_usesRt,
  input  logic             idex_memRead,
  input  logic             idex_regWrite,
  input  logic [4:0]       idex_regSel,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_regWrite,
  input  logic [4:0]       exmem_regSel,
  input  logic             memwb_regWrite,
  input  logic [4:0]       memwb_regSel,
  input  logic             branchCtrl,
  output logic             pcWrite,
  output logic             IFIDWrite,
  output logic             IFFlush,
  output logic             IDEXFlush,
  output logic             EXMEMFlush,
  output logic [2:0]       PCSrc,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  ctl_t             ctl;
  logic             load_use, jr_wait, stall_inc, flush_inc;

  assign load_use = idex_memRead && idex_regSel != 5'd0 &&
                    (idex_regSel == ifid_rs || (ifid_usesRt && idex_regSel == ifid_rt));
  // jr reads its target in ID, so it must wait until the producer has left EX.
  assign jr_wait  = ifid_opCode == OP_JR && idex_regWrite && idex_regSel != 5'd0 &&
                    idex_regSel == ifid_rs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = (state_q != INIT && branchCtrl) ? FLUSH : RUN;
  end

  // A pending FLUSH means ID/EX hold bubbles, so only a new branch is honoured.
  always_comb begin
    ctl       = CTL_RESET;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (state_q != INIT) begin
      if (branchCtrl) begin
        ctl       = CTL_BR;
        flush_inc = 1'b1;
      end else if (state_q == FLUSH) begin
        ctl = CTL_SEQ;
      end else if (load_use || jr_wait) begin
        ctl       = CTL_STALL;
        stall_inc = 1'b1;
      end else if (ifid_opCode == OP_J || ifid_opCode == OP_JR) begin
        ctl       = ifid_opCode == OP_J ? CTL_J : CTL_JR;
        flush_inc = 1'b1;
      end else begin
        ctl = CTL_SEQ;
      end
    end
  end

  assign stall_d = (stall_inc && stall_q != '1) ? stall_q + 1'b1 : stall_q;
  assign flush_d = (flush_inc && flush_q != '1) ? flush_q + 1'b1 : flush_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  forward_unit u_fwd (
    .en_i       (state_q != INIT),
    .exmem_we_i (exmem_regWrite),
    .exmem_rd_i (exmem_regSel),
    .memwb_we_i (memwb_regWrite),
    .memwb_rd_i (memwb_regSel),
    .idex_rs_i  (idex_rs),
    .idex_rt_i  (idex_rt),
    .fwd_a_o    (forwardA),
    .fwd_b_o    (forwardB)
  );

  assign pcWrite    = ctl.pc_write;
  assign IFIDWrite  = ctl.ifid_write;
  assign IFFlush    = ctl.if_flush;
  assign IDEXFlush  = ctl.idex_flush;
  assign EXMEMFlush = ctl.exmem_flush;
  assign PCSrc      = ctl.pc_src;
  assign stallCount = stall_q;
  assign flushCount = flush_q;

endmodule
